// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue front-end: opcodes, FSM states and the queued command entry.
package alu_issue_pkg;

    localparam int ISSUE_WIDTH = 4;
    localparam int ISSUE_TAG_W = 4;

    localparam logic [ISSUE_WIDTH-1:0] OP_ADD = ISSUE_WIDTH'(0);
    localparam logic [ISSUE_WIDTH-1:0] OP_SUB = ISSUE_WIDTH'(1);
    localparam logic [ISSUE_WIDTH-1:0] OP_MUL = ISSUE_WIDTH'(2);
    localparam logic [ISSUE_WIDTH-1:0] OP_DIV = ISSUE_WIDTH'(3);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESULT = 3'd5
    } issue_state_t;

    // Entry widths are fixed here; the top's WIDTH/TAG_W default to these values.
    typedef struct packed {
        logic [ISSUE_TAG_W-1:0] tag;
        logic [ISSUE_WIDTH-1:0] opcode;
        logic [ISSUE_WIDTH-1:0] in1;
        logic [ISSUE_WIDTH-1:0] in2;
    } cmd_entry_t;

    function automatic logic op_is_legal(input logic [ISSUE_WIDTH-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Command and result handshakes of the ALU issue unit.
interface alu_issue_if #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_opcode;
    logic [WIDTH-1:0] cmd_in1;
    logic [WIDTH-1:0] cmd_in2;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_high;
    logic [WIDTH-1:0] res_low;
    logic             res_flag;
    logic             res_err;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_in1, cmd_in2, res_ready,
        input  cmd_ready, res_valid, res_high, res_low, res_flag, res_err, res_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_in1, cmd_in2, res_ready,
        output cmd_ready, res_valid, res_high, res_low, res_flag, res_err, res_tag
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead FIFO; rd_data always presents the head entry.
module alu_cmd_fifo #(
    parameter int ENTRY_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic                     rd_en,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front-end for Sequential_ALU: queues commands, sequences clear/settle/start/wait,
// and returns tagged results with an error flag for illegal opcodes or watchdog expiry.
//
// state     | meaning
// IDLE      | pop head if queued; legal -> CLEAR, illegal -> RESULT with err
// CLEAR     | alu_clear high for one cycle
// SETTLE    | one quiet cycle after clear
// START     | alu_start high for one cycle, watchdog loaded
// WAIT      | wait for alu_done or watchdog terminal count
// RESULT    | res_valid held until res_ready
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int WIDTH   = ISSUE_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = ISSUE_TAG_W,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_issue_if.slave             bus,
    output logic                   alu_clear,
    output logic                   alu_start,
    output logic [WIDTH-1:0]       alu_opcode,
    output logic [WIDTH-1:0]       alu_in1,
    output logic [WIDTH-1:0]       alu_in2,
    input  logic [WIDTH-1:0]       alu_high,
    input  logic [WIDTH-1:0]       alu_low,
    input  logic                   alu_flag,
    input  logic                   alu_done,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    issue_state_t     state, state_nxt;
    cmd_entry_t       push_entry, head_entry;
    logic             fifo_full, fifo_empty;
    logic             push, pop, head_legal;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] cur_tag;
    logic [WD_W-1:0]  wd_cnt;

    assign bus.cmd_ready = !fifo_full;
    assign bus.res_valid = (state == ST_RESULT);
    assign push          = bus.cmd_valid && !fifo_full;
    assign pop           = (state == ST_IDLE) && !fifo_empty;
    assign head_legal    = op_is_legal(head_entry.opcode);
    assign push_entry    = '{tag: tag_cnt, opcode: bus.cmd_opcode, in1: bus.cmd_in1, in2: bus.cmd_in2};

    alu_cmd_fifo #(
        .ENTRY_W ($bits(cmd_entry_t)),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!fifo_empty) state_nxt = head_legal ? ST_CLEAR : ST_RESULT;
            ST_CLEAR:  state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_START;
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT:   if (alu_done || wd_cnt == '0) state_nxt = ST_RESULT;
            ST_RESULT: if (bus.res_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tag_cnt <= '0;
        else if (push)
            tag_cnt <= tag_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            alu_clear    <= 1'b0;
            alu_start    <= 1'b0;
            alu_opcode   <= '0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            cur_tag      <= '0;
            wd_cnt       <= '0;
            bus.res_high <= '0;
            bus.res_low  <= '0;
            bus.res_flag <= 1'b0;
            bus.res_err  <= 1'b0;
            bus.res_tag  <= '0;
        end else begin
            state     <= state_nxt;
            // Registered strobes keep the ALU's clear/start lines free of decode glitches.
            alu_clear <= (state_nxt == ST_CLEAR);
            alu_start <= (state_nxt == ST_START);

            if (pop) begin
                cur_tag <= head_entry.tag;
                if (head_legal) begin
                    alu_opcode <= head_entry.opcode;
                    alu_in1    <= head_entry.in1;
                    alu_in2    <= head_entry.in2;
                end else begin
                    bus.res_high <= '0;
                    bus.res_low  <= '0;
                    bus.res_flag <= 1'b0;
                    bus.res_err  <= 1'b1;
                    bus.res_tag  <= head_entry.tag;
                end
            end

            if (state == ST_START)
                wd_cnt <= WD_W'(TIMEOUT - 1);
            else if (state == ST_WAIT && wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;

            // A done in the terminal-count cycle still wins over the timeout.
            if (state == ST_WAIT) begin
                if (alu_done) begin
                    bus.res_high <= alu_high;
                    bus.res_low  <= alu_low;
                    bus.res_flag <= alu_flag;
                    bus.res_err  <= 1'b0;
                    bus.res_tag  <= cur_tag;
                end else if (wd_cnt == '0) begin
                    bus.res_high <= '0;
                    bus.res_low  <= '0;
                    bus.res_flag <= 1'b0;
                    bus.res_err  <= 1'b1;
                    bus.res_tag  <= cur_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a stub ALU that returns in1*in2 after a set delay.
module tb_alu_issue_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_clear, alu_start;
    logic [3:0] alu_opcode, alu_in1, alu_in2;
    logic [3:0] alu_high, alu_low;
    logic       alu_flag, alu_done;
    logic [2:0] fifo_count;

    alu_issue_if #(.WIDTH(4), .TAG_W(4)) bus ();

    alu_issue_unit #(.WIDTH(4), .DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .alu_clear  (alu_clear),
        .alu_start  (alu_start),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_high   (alu_high),
        .alu_low    (alu_low),
        .alu_flag   (alu_flag),
        .alu_done   (alu_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // stub ALU: done is sampled stub_delay cycles after the start cycle; 0 = never
    int         stub_delay = 0;
    int         stub_cnt   = 0;
    logic [7:0] prod;

    initial begin
        alu_done = 1'b0;
        alu_high = '0;
        alu_low  = '0;
        alu_flag = 1'b0;
    end

    always @(negedge clk) begin
        alu_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                prod     = {4'b0, alu_in1} * {4'b0, alu_in2};
                alu_high = prod[7:4];
                alu_low  = prod[3:0];
                alu_flag = alu_in1[0];
                alu_done = 1'b1;
            end
        end
        if (alu_start && stub_delay > 0)
            stub_cnt = stub_delay;
    end

    // event monitor, sampled 1 time unit after each rising edge
    int   cyc = 0;
    int   clear_cyc = -1, start_cyc = -1, rv_cyc = -1;
    int   clear_cnt = 0, start_cnt = 0, rv_cnt = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (alu_clear) begin clear_cyc = cyc; clear_cnt++; end
        if (alu_start) begin start_cyc = cyc; start_cnt++; end
        if (bus.res_valid && !rv_prev) begin rv_cyc = cyc; rv_cnt++; end
        rv_prev = bus.res_valid;
    end

    task automatic do_reset();
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        stub_delay    = 0;
        stub_cnt      = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                            output int pcyc);
        int guard = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_in1    = a;
        bus.cmd_in2    = b;
        while (!bus.cmd_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("push_timeout", 32'd1, 32'd0);
        pcyc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [3:0] tag, input logic [3:0] hi,
                               input logic [3:0] lo, input logic fl, input logic err);
        int guard = 0;
        while (!bus.res_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            chk({name, "_res_timeout"}, 32'd1, 32'd0);
        end else begin
            chk({name, "_tag"},  32'(bus.res_tag),  32'(tag));
            chk({name, "_high"}, 32'(bus.res_high), 32'(hi));
            chk({name, "_low"},  32'(bus.res_low),  32'(lo));
            chk({name, "_flag"}, 32'(bus.res_flag), 32'(fl));
            chk({name, "_err"},  32'(bus.res_err),  32'(err));
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] op, a, b, hi, lo;
        logic       fl;
    } vec_t;

    vec_t vecs[6] = '{
        '{4'd0, 4'd1,  4'd2,  4'h0, 4'h2, 1'b1},
        '{4'd1, 4'd3,  4'd5,  4'h0, 4'hF, 1'b1},
        '{4'd2, 4'd4,  4'd4,  4'h1, 4'h0, 1'b0},
        '{4'd3, 4'd15, 4'd15, 4'hE, 4'h1, 1'b1},
        '{4'd2, 4'd6,  4'd7,  4'h2, 4'hA, 1'b0},
        '{4'd0, 4'd2,  4'd9,  4'h1, 4'h2, 1'b0}
    };

    initial begin
        int pcyc, s0, c0, rv0, guard;
        bus.cmd_opcode = '0;
        bus.cmd_in1    = '0;
        bus.cmd_in2    = '0;

        // reset values
        do_reset();
        chk("rst_cmd_ready",  32'(bus.cmd_ready), 32'd1);
        chk("rst_res_valid",  32'(bus.res_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count),    32'd0);
        chk("rst_alu_clear",  32'(alu_clear),     32'd0);
        chk("rst_alu_start",  32'(alu_start),     32'd0);

        // single mul: 7*9 = 0x3F, done sampled 5 cycles after start
        stub_delay    = 5;
        bus.res_ready = 1'b1;
        push_cmd(4'd2, 4'd7, 4'd9, pcyc);
        wait_result("mul", 4'd0, 4'h3, 4'hF, 1'b1, 1'b0);
        chk("mul_clear_cyc", 32'(clear_cyc), 32'(pcyc + 2));
        chk("mul_start_cyc", 32'(start_cyc), 32'(pcyc + 4));
        chk("mul_rv_cyc",    32'(rv_cyc),    32'(start_cyc + 6));
        chk("mul_alu_op",    32'(alu_opcode), 32'd2);

        // fill the queue behind a stalled result, then drain in order
        do_reset();
        stub_delay = 2;
        for (int i = 0; i < 5; i++)
            push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, pcyc);
        chk("full_count", 32'(fifo_count),    32'd4);
        chk("full_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = vecs[5].op;
        bus.cmd_in1    = vecs[5].a;
        bus.cmd_in2    = vecs[5].b;
        repeat (3) @(negedge clk);
        chk("stall_count", 32'(fifo_count),    32'd4);
        chk("stall_ready", 32'(bus.cmd_ready), 32'd0);
        bus.res_ready = 1'b1;
        fork
            begin
                int pc;
                push_cmd(vecs[5].op, vecs[5].a, vecs[5].b, pc);
            end
            begin
                for (int i = 0; i < 6; i++)
                    wait_result($sformatf("ord%0d", i), 4'(i), vecs[i].hi, vecs[i].lo,
                                vecs[i].fl, 1'b0);
            end
        join

        // illegal opcode: result on the cycle after pop, ALU untouched
        s0 = start_cnt;
        c0 = clear_cnt;
        @(negedge clk);
        push_cmd(4'd9, 4'd3, 4'd3, pcyc);
        wait_result("ill", 4'd6, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("ill_rv_cyc", 32'(rv_cyc),    32'(pcyc + 2));
        chk("ill_start",  32'(start_cnt), 32'(s0));
        chk("ill_clear",  32'(clear_cnt), 32'(c0));

        // watchdog: done never comes
        stub_delay = 0;
        push_cmd(4'd0, 4'd1, 4'd1, pcyc);
        wait_result("tmo", 4'd7, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("tmo_rv_cyc", 32'(rv_cyc), 32'(start_cyc + 65));
        stub_delay = 1;
        push_cmd(4'd2, 4'd5, 4'd3, pcyc);
        wait_result("post_tmo", 4'd8, 4'h0, 4'hF, 1'b1, 1'b0);

        // reset while in WAIT with two entries queued
        stub_delay    = 0;
        bus.res_ready = 1'b0;
        s0 = start_cnt;
        push_cmd(4'd0, 4'd1, 4'd1, pcyc);
        push_cmd(4'd1, 4'd2, 4'd2, pcyc);
        push_cmd(4'd2, 4'd3, 4'd3, pcyc);
        guard = 0;
        while (start_cnt == s0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rstw_started", 32'(start_cnt), 32'(s0 + 1));
        repeat (3) @(negedge clk);
        chk("rstw_pre_count", 32'(fifo_count), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("rstw_count",     32'(fifo_count),    32'd0);
        chk("rstw_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rstw_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rstw_alu_start", 32'(alu_start),     32'd0);
        chk("rstw_alu_clear", 32'(alu_clear),     32'd0);
        repeat (2) @(negedge clk);
        reset         = 1'b1;
        stub_delay    = 1;
        bus.res_ready = 1'b1;
        rv0 = rv_cnt;
        s0  = start_cnt;
        repeat (60) @(negedge clk);
        chk("rstw_no_result", 32'(rv_cnt),    32'(rv0));
        chk("rstw_no_start",  32'(start_cnt), 32'(s0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
